// File: rtl/snitch_sequencer_flush_if.sv
// Offload request bus shared by the sequencer input and output sides.
package snitch_sequencer_flush_pkg;
  typedef enum logic [1:0] {
    FP_SS         = 2'd0,
    SHARED_MULDIV = 2'd1,
    DMA_SS        = 2'd2,
    INT_SS        = 2'd3
  } acc_addr_e;
endpackage

interface snitch_sequencer_flush_if
  import snitch_sequencer_flush_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  acc_addr_e             qaddr;
  logic [4:0]            qid;
  logic [31:0]           qdata_op;
  logic [DataWidth-1:0]  qdata_arga;
  logic [DataWidth-1:0]  qdata_argb;
  logic [AddrWidth-1:0]  qdata_argc;
  logic                  qvalid;
  logic                  qready;

  modport master (
    output qaddr, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc, qvalid,
    input  qready
  );
  modport slave (
    input  qaddr, qid, qdata_op, qdata_arga, qdata_argb, qdata_argc, qvalid,
    output qready
  );
endinterface

// File: rtl/snitch_sequencer_flush.sv
// FPU offload sequencer: ring buffer with loop replay, register staggering,
// direct passthrough when idle, synchronous flush and busy status.
module snitch_sequencer_flush
  import snitch_sequencer_flush_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned Depth       = 16,
  parameter int unsigned CfgDepth    = 4,
  parameter int unsigned RptBits     = 16,
  parameter int unsigned StaggerBits = 3,
  parameter acc_addr_e   DstAddr     = FP_SS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [1:0]               inp_qkind_i,
  snitch_sequencer_flush_if.slave  inp,
  snitch_sequencer_flush_if.master oup,
  output logic                     oup_qdata_repd_o,
  output logic                     oup_qdata_last_o,
  output logic                     busy_o
);
  localparam int unsigned DepthBits = $clog2(Depth);
  localparam int unsigned CfgBits   = $clog2(CfgDepth);

  typedef struct packed {
    logic                   is_outer;
    logic [3:0]             stagger_mask;
    logic [StaggerBits-1:0] stagger_max;
    logic [DepthBits-1:0]   max_inst;
    logic [RptBits-1:0]     max_rpt;
    logic [DepthBits:0]     base;
  } cfg_t;

  logic [31:0]          mem_op_q   [Depth];
  logic [AddrWidth-1:0] mem_argc_q [Depth];
  cfg_t                 cfg_q      [CfgDepth];

  logic [DepthBits:0]     rd_q, rd_d, wr_q, wr_d, rb_count;
  logic [CfgBits:0]       cfg_rd_q, cfg_rd_d, cfg_wr_q, cfg_wr_d;
  logic [DepthBits-1:0]   inst_cnt_q, inst_cnt_d, rd_idx;
  logic [RptBits-1:0]     rpt_cnt_q, rpt_cnt_d;
  logic [StaggerBits-1:0] stagger_cnt_q, stagger_cnt_d, stagger_nxt;

  logic rb_full, rb_empty, cfg_full, cfg_empty, cfg_active;
  logic is_cfg, is_dir, buf_push, cfg_push;
  logic issue_valid, issue_hs, issue_last;
  cfg_t cfg_head, cur, cfg_new;
  logic [31:0] op_stag;
  logic [4:0]  stag5;

  assign rb_full   = (rd_q ^ wr_q) == {1'b1, {DepthBits{1'b0}}};
  assign rb_empty  = rd_q == wr_q;
  assign rb_count  = wr_q - rd_q;
  assign cfg_full  = (cfg_rd_q ^ cfg_wr_q) == {1'b1, {CfgBits{1'b0}}};
  assign cfg_empty = cfg_rd_q == cfg_wr_q;
  assign cfg_head  = cfg_q[cfg_rd_q[CfgBits-1:0]];
  // A queued config only governs the entry it was recorded against.
  assign cfg_active = !cfg_empty && (cfg_head.base == rd_q);
  assign cur        = cfg_active ? cfg_head : '0;
  assign busy_o     = !rb_empty || !cfg_empty;

  assign is_cfg = inp_qkind_i == 2'd1;
  assign is_dir = inp_qkind_i == 2'd2;

  always_comb begin
    inp.qready = 1'b0;
    if (!flush_i) begin
      if (is_cfg)      inp.qready = !cfg_full;
      else if (is_dir) inp.qready = rb_empty && oup.qready;
      else             inp.qready = !rb_full;
    end
  end

  assign buf_push = inp.qvalid && inp.qready && !is_cfg && !is_dir;
  assign cfg_push = inp.qvalid && inp.qready && is_cfg;

  always_comb begin
    cfg_new              = '0;
    cfg_new.is_outer     = inp.qdata_op[7];
    cfg_new.stagger_mask = inp.qdata_op[11:8];
    cfg_new.stagger_max  = inp.qdata_op[12 +: StaggerBits];
    cfg_new.max_inst     = inp.qdata_op[20 +: DepthBits];
    cfg_new.max_rpt      = inp.qdata_op[RptBits-1:0] & '0 | inp.qdata_arga[RptBits-1:0];
    cfg_new.base         = wr_q;
  end

  assign rd_idx      = rd_q[DepthBits-1:0] + inst_cnt_q;
  assign issue_valid = ({1'b0, inst_cnt_q} < rb_count) && !flush_i;
  assign issue_hs    = issue_valid && oup.qready;
  assign issue_last  = (inst_cnt_q == cur.max_inst) && (rpt_cnt_q == cur.max_rpt);
  assign stagger_nxt = (stagger_cnt_q == cur.stagger_max) ? '0 : stagger_cnt_q + StaggerBits'(1);

  always_comb begin
    op_stag = mem_op_q[rd_idx];
    stag5   = 5'(stagger_cnt_q);
    if (cur.stagger_mask[0]) op_stag[11:7]  = op_stag[11:7]  + stag5;
    if (cur.stagger_mask[1]) op_stag[19:15] = op_stag[19:15] + stag5;
    if (cur.stagger_mask[2]) op_stag[24:20] = op_stag[24:20] + stag5;
    if (cur.stagger_mask[3]) op_stag[31:27] = op_stag[31:27] + stag5;
  end

  always_comb begin
    oup.qaddr        = inp.qaddr;
    oup.qid          = inp.qid;
    oup.qdata_op     = inp.qdata_op;
    oup.qdata_arga   = inp.qdata_arga;
    oup.qdata_argb   = inp.qdata_argb;
    oup.qdata_argc   = inp.qdata_argc;
    oup.qvalid       = inp.qvalid && is_dir && !flush_i;
    oup_qdata_repd_o = 1'b0;
    oup_qdata_last_o = 1'b0;
    if (!rb_empty) begin
      oup.qaddr        = DstAddr;
      oup.qid          = '0;
      oup.qdata_op     = op_stag;
      oup.qdata_arga   = '0;
      oup.qdata_argb   = '0;
      oup.qdata_argc   = mem_argc_q[rd_idx];
      oup.qvalid       = issue_valid;
      oup_qdata_repd_o = rpt_cnt_q != '0;
      oup_qdata_last_o = issue_last;
    end
  end

  always_comb begin
    rd_d          = rd_q;
    wr_d          = wr_q;
    cfg_rd_d      = cfg_rd_q;
    cfg_wr_d      = cfg_wr_q;
    inst_cnt_d    = inst_cnt_q;
    rpt_cnt_d     = rpt_cnt_q;
    stagger_cnt_d = stagger_cnt_q;
    if (buf_push) wr_d = wr_q + (DepthBits+1)'(1);
    if (cfg_push) cfg_wr_d = cfg_wr_q + (CfgBits+1)'(1);
    if (issue_hs) begin
      if (issue_last) begin
        rd_d          = rd_q + (DepthBits+1)'(cur.max_inst) + (DepthBits+1)'(1);
        inst_cnt_d    = '0;
        rpt_cnt_d     = '0;
        stagger_cnt_d = '0;
        if (cfg_active) cfg_rd_d = cfg_rd_q + (CfgBits+1)'(1);
      end else if (!cur.is_outer) begin
        stagger_cnt_d = stagger_nxt;
        if (rpt_cnt_q == cur.max_rpt) begin
          rpt_cnt_d  = '0;
          inst_cnt_d = inst_cnt_q + DepthBits'(1);
        end else begin
          rpt_cnt_d  = rpt_cnt_q + RptBits'(1);
        end
      end else if (inst_cnt_q == cur.max_inst) begin
        inst_cnt_d    = '0;
        rpt_cnt_d     = rpt_cnt_q + RptBits'(1);
        stagger_cnt_d = stagger_nxt;
      end else begin
        inst_cnt_d = inst_cnt_q + DepthBits'(1);
      end
    end
    if (flush_i) begin
      rd_d          = wr_q;
      cfg_rd_d      = cfg_wr_q;
      inst_cnt_d    = '0;
      rpt_cnt_d     = '0;
      stagger_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q          <= '0;
      wr_q          <= '0;
      cfg_rd_q      <= '0;
      cfg_wr_q      <= '0;
      inst_cnt_q    <= '0;
      rpt_cnt_q     <= '0;
      stagger_cnt_q <= '0;
    end else begin
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      cfg_rd_q      <= cfg_rd_d;
      cfg_wr_q      <= cfg_wr_d;
      inst_cnt_q    <= inst_cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      stagger_cnt_q <= stagger_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (buf_push) begin
      mem_op_q[wr_q[DepthBits-1:0]]   <= inp.qdata_op;
      mem_argc_q[wr_q[DepthBits-1:0]] <= inp.qdata_argc;
    end
    if (cfg_push) cfg_q[cfg_wr_q[CfgBits-1:0]] <= cfg_new;
  end

  // A full buffer must hold the whole active body, otherwise issue deadlocks.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    rb_full |-> ({1'b0, cur.max_inst} < rb_count));
endmodule

// File: tb/tb_snitch_sequencer_flush.sv
// Directed self-checking bench for snitch_sequencer_flush.
module tb_snitch_sequencer_flush;
  import snitch_sequencer_flush_pkg::*;

  localparam int Depth = 16;
  localparam logic [31:0] OP_A = 32'h0000_0253;
  localparam logic [31:0] OP_B = 32'h0010_0253;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [1:0] inp_qkind = 2'd0;
  logic repd, last, busy;
  int total = 0;
  int bad = 0;

  snitch_sequencer_flush_if inp_if ();
  snitch_sequencer_flush_if oup_if ();

  snitch_sequencer_flush dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .inp_qkind_i      (inp_qkind),
    .inp              (inp_if),
    .oup              (oup_if),
    .oup_qdata_repd_o (repd),
    .oup_qdata_last_o (last),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [1:0] kind, input logic [31:0] op,
                      input logic [63:0] arga, input logic [31:0] argc);
    int n;
    n = 0;
    @(negedge clk);
    inp_qkind         = kind;
    inp_if.qdata_op   = op;
    inp_if.qdata_arga = arga;
    inp_if.qdata_argc = argc;
    inp_if.qvalid     = 1'b1;
    #1;
    while (!inp_if.qready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!inp_if.qready) begin
      total++; bad++;
      $display("FAIL push_timeout: ready=%b want 1", inp_if.qready);
    end
    @(posedge clk); #1;
    inp_if.qvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (oup_if.qvalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", oup_if.qvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({repd, last} !== 2'b00) begin bad++; $display("FAIL reset_repd_last: got %b want 00", {repd, last}); end
    for (int k = 0; k < 4; k++) begin
      inp_qkind = 2'(k);
      #1;
      total++;
      if (inp_if.qready !== (k != 2)) begin
        bad++; $display("FAIL reset_ready_kind%0d: got %b want %b", k, inp_if.qready, (k != 2));
      end
    end
  endtask

  task automatic test_direct();
    @(negedge clk);
    oup_if.qready     = 1'b1;
    inp_qkind         = 2'd2;
    inp_if.qaddr      = DMA_SS;
    inp_if.qid        = 5'd7;
    inp_if.qdata_op   = 32'hE000_0053;
    inp_if.qdata_arga = 64'h1234;
    inp_if.qdata_argb = 64'h5678;
    inp_if.qdata_argc = 32'hABCD;
    inp_if.qvalid     = 1'b1;
    #1;
    total++; if (oup_if.qvalid !== 1'b1) begin bad++; $display("FAIL direct_valid: got %b want 1", oup_if.qvalid); end
    total++;
    if ({oup_if.qaddr, oup_if.qid, oup_if.qdata_op, oup_if.qdata_arga, oup_if.qdata_argb, oup_if.qdata_argc} !==
        {DMA_SS, 5'd7, 32'hE000_0053, 64'h1234, 64'h5678, 32'hABCD}) begin
      bad++; $display("FAIL direct_fields: got op %h argc %h want op e0000053 argc abcd", oup_if.qdata_op, oup_if.qdata_argc);
    end
    total++; if ({repd, last} !== 2'b00) begin bad++; $display("FAIL direct_repd_last: got %b want 00", {repd, last}); end
    total++; if (inp_if.qready !== 1'b1) begin bad++; $display("FAIL direct_ready: got %b want 1", inp_if.qready); end
    oup_if.qready = 1'b0;
    #1;
    total++; if (inp_if.qready !== 1'b0) begin bad++; $display("FAIL direct_backpressure: got %b want 0", inp_if.qready); end
    inp_if.qvalid = 1'b0;
    inp_if.qaddr  = FP_SS;
    inp_if.qid    = 5'd0;
  endtask

  task automatic test_inner();
    logic [31:0] exp_op [6] = '{OP_A, OP_A, OP_A, OP_B, OP_B, OP_B};
    logic [5:0] exp_repd = 6'b110110;
    logic [5:0] exp_last = 6'b100000;
    oup_if.qready = 1'b0;
    push(2'd1, 32'h0010_0000, 64'd2, 32'd0);
    push(2'd0, OP_A, 64'd0, 32'hA);
    push(2'd0, OP_B, 64'd0, 32'hB);
    oup_if.qready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      total++; if (oup_if.qvalid !== 1'b1) begin bad++; $display("FAIL inner_valid_%0d: got %b want 1", k, oup_if.qvalid); end
      total++;
      if ({oup_if.qdata_op, repd, last} !== {exp_op[k], exp_repd[k], exp_last[k]}) begin
        bad++; $display("FAIL inner_issue_%0d: got op %h repd %b last %b want op %h repd %b last %b",
                        k, oup_if.qdata_op, repd, last, exp_op[k], exp_repd[k], exp_last[k]);
      end
      if (k == 0 || k == 3) begin
        total++;
        if ({oup_if.qaddr, oup_if.qid, oup_if.qdata_arga, oup_if.qdata_argc} !== {FP_SS, 5'd0, 64'd0, (k == 0) ? 32'hA : 32'hB}) begin
          bad++; $display("FAIL inner_side_%0d: got addr %0d id %0d argc %h", k, oup_if.qaddr, oup_if.qid, oup_if.qdata_argc);
        end
      end
    end
    @(negedge clk); #1;
    total++; if ({oup_if.qvalid, busy} !== 2'b00) begin bad++; $display("FAIL inner_done: got valid,busy %b want 00", {oup_if.qvalid, busy}); end
  endtask

  task automatic test_outer_stagger();
    logic [31:0] exp_op [4] = '{OP_A, OP_B, 32'h0000_02D3, 32'h0010_02D3};
    logic [3:0] exp_repd = 4'b1100;
    logic [3:0] exp_last = 4'b1000;
    oup_if.qready = 1'b0;
    push(2'd1, 32'h0010_1180, 64'd1, 32'd0);
    push(2'd0, OP_A, 64'd0, 32'd0);
    push(2'd0, OP_B, 64'd0, 32'd0);
    oup_if.qready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++;
      if ({oup_if.qvalid, oup_if.qdata_op, repd, last} !== {1'b1, exp_op[k], exp_repd[k], exp_last[k]}) begin
        bad++; $display("FAIL outer_issue_%0d: got v %b op %h repd %b last %b want op %h repd %b last %b",
                        k, oup_if.qvalid, oup_if.qdata_op, repd, last, exp_op[k], exp_repd[k], exp_last[k]);
      end
    end
    @(negedge clk); #1;
    total++; if ({oup_if.qvalid, busy} !== 2'b00) begin bad++; $display("FAIL outer_done: got valid,busy %b want 00", {oup_if.qvalid, busy}); end
  endtask

  task automatic test_full();
    oup_if.qready = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      push(2'd0, 32'h1000_0000 + 32'(i), 64'd0, 32'(i));
      total++;
      if (inp_if.qready !== (i + 1 < Depth)) begin
        bad++; $display("FAIL full_ready_after_%0d: got %b want %b", i + 1, inp_if.qready, (i + 1 < Depth));
      end
    end
    inp_qkind = 2'd1;
    #1;
    total++; if (inp_if.qready !== 1'b1) begin bad++; $display("FAIL full_cfg_ready: got %b want 1", inp_if.qready); end
    @(negedge clk);
    inp_qkind       = 2'd2;
    inp_if.qdata_op = 32'hE000_0053;
    inp_if.qvalid   = 1'b1;
    oup_if.qready   = 1'b1;
    #1;
    total++; if (inp_if.qready !== 1'b0) begin bad++; $display("FAIL full_direct_blocked: got %b want 0", inp_if.qready); end
    total++; if (oup_if.qdata_op !== 32'h1000_0000) begin bad++; $display("FAIL full_head_op: got %h want 10000000", oup_if.qdata_op); end
    inp_if.qvalid = 1'b0;
    inp_qkind     = 2'd0;
    for (int k = 1; k < Depth; k++) begin
      @(negedge clk); #1;
      total++;
      if ({oup_if.qvalid, oup_if.qdata_op} !== {1'b1, 32'h1000_0000 + 32'(k)}) begin
        bad++; $display("FAIL full_drain_%0d: got v %b op %h want op %h", k, oup_if.qvalid, oup_if.qdata_op, 32'h1000_0000 + 32'(k));
      end
      if (k == 1) begin
        total++; if (inp_if.qready !== 1'b1) begin bad++; $display("FAIL full_ready_restored: got %b want 1", inp_if.qready); end
      end
    end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_drained_busy: got %b want 0", busy); end
  endtask

  task automatic test_flush();
    oup_if.qready = 1'b0;
    push(2'd1, 32'h0000_0000, 64'd100, 32'd0);
    push(2'd0, OP_A, 64'd0, 32'd0);
    oup_if.qready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      total++;
      if ({oup_if.qvalid, repd, last} !== {1'b1, (k != 0), 1'b0}) begin
        bad++; $display("FAIL flush_issue_%0d: got v %b repd %b last %b want 1 %b 0", k, oup_if.qvalid, repd, last, (k != 0));
      end
    end
    @(negedge clk);
    flush             = 1'b1;
    inp_qkind         = 2'd0;
    inp_if.qdata_op   = OP_B;
    inp_if.qvalid     = 1'b1;
    #1;
    total++; if ({oup_if.qvalid, inp_if.qready} !== 2'b00) begin bad++; $display("FAIL flush_cycle: got valid,ready %b want 00", {oup_if.qvalid, inp_if.qready}); end
    @(posedge clk); #1;
    flush         = 1'b0;
    inp_if.qvalid = 1'b0;
    @(negedge clk); #1;
    total++; if ({busy, oup_if.qvalid} !== 2'b00) begin bad++; $display("FAIL flush_after: got busy,valid %b want 00", {busy, oup_if.qvalid}); end
    inp_qkind       = 2'd2;
    inp_if.qdata_op = 32'hE000_0053;
    inp_if.qvalid   = 1'b1;
    #1;
    total++;
    if ({oup_if.qvalid, inp_if.qready, oup_if.qdata_op} !== {1'b1, 1'b1, 32'hE000_0053}) begin
      bad++; $display("FAIL flush_direct: got v %b r %b op %h want 1 1 e0000053", oup_if.qvalid, inp_if.qready, oup_if.qdata_op);
    end
    inp_if.qvalid = 1'b0;
    inp_qkind     = 2'd0;
  endtask

  task automatic test_wrap();
    oup_if.qready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3 * Depth; i++) push(2'd0, 32'h2000_0000 + 32'(i), 64'd0, 32'(i));
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 3 * Depth && cyc < 1000) begin
          @(negedge clk); #1; cyc++;
          if (oup_if.qvalid) begin
            total++;
            if (oup_if.qdata_op !== 32'h2000_0000 + 32'(got)) begin
              bad++; $display("FAIL wrap_order_%0d: got %h want %h", got, oup_if.qdata_op, 32'h2000_0000 + 32'(got));
            end
            got++;
          end
        end
        if (got < 3 * Depth) begin
          total++; bad++; $display("FAIL wrap_timeout: got %0d issues want %0d", got, 3 * Depth);
        end
      end
    join
    @(negedge clk); #1;
    total++; if ({busy, oup_if.qvalid} !== 2'b00) begin bad++; $display("FAIL wrap_done: got busy,valid %b want 00", {busy, oup_if.qvalid}); end
  endtask

  initial begin
    inp_if.qaddr      = FP_SS;
    inp_if.qid        = 5'd0;
    inp_if.qdata_op   = 32'd0;
    inp_if.qdata_arga = 64'd0;
    inp_if.qdata_argb = 64'd0;
    inp_if.qdata_argc = 32'd0;
    inp_if.qvalid     = 1'b0;
    oup_if.qready     = 1'b0;
    test_reset();
    test_direct();
    test_inner();
    test_outer_stagger();
    test_full();
    test_flush();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
